// File: rtl/cla_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared CLA4 slice, low nibble first, carry fed back.
// Optional subtract mode (sub port, A-B) is enabled by defining CLA_SERIAL_SUB_EN.
module cla_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             PG,
    output logic             GG,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [3:0] sum;
        logic       co;
        logic       pg;
        logic       gg;
    } cla4_t;

    // 4-bit carry-lookahead slice with group propagate/generate.
    function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        cla4_t      r;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        r.pg = &p;
        r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        c[4] = r.gg | (r.pg & c[0]);
        r.sum = p ^ c[3:0];
        r.co  = c[4];
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic             pg_acc_q, pg_acc_d;
    logic             gg_acc_q, gg_acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             pg_q, pg_d;
    logic             gg_q, gg_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    cla4_t            slice;

    // b_q always holds the operand actually added, so PG/GG/ovf see Beff.
`ifdef CLA_SERIAL_SUB_EN
    assign b_cap = sub ? ~B : B;
    assign c_cap = sub ? 1'b1 : Ci;
`else
    assign b_cap = B;
    assign c_cap = Ci;
`endif

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign slice = cla4(a_nib, b_nib, carry_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        pg_acc_d    = pg_acc_q;
        gg_acc_d    = gg_acc_q;
        s_d         = s_q;
        co_d        = co_q;
        pg_d        = pg_q;
        gg_d        = gg_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = b_cap;
                    carry_d  = c_cap;
                    idx_d    = '0;
                    pg_acc_d = 1'b1;
                    gg_acc_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 2'b00} +: 4] = slice.sum;
                carry_d  = slice.co;
                pg_acc_d = pg_acc_q & slice.pg;
                gg_acc_d = slice.gg | (slice.pg & gg_acc_q);
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    co_d        = slice.co;
                    pg_d        = pg_acc_q & slice.pg;
                    gg_d        = slice.gg | (slice.pg & gg_acc_q);
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice.sum[3] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            pg_acc_q    <= 1'b1;
            gg_acc_q    <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            pg_q        <= 1'b0;
            gg_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            pg_acc_q    <= pg_acc_d;
            gg_acc_q    <= gg_acc_d;
            s_q         <= s_d;
            co_q        <= co_d;
            pg_q        <= pg_d;
            gg_q        <= gg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Co        = co_q;
    assign PG        = pg_q;
    assign GG        = gg_q;
    assign ovf       = ovf_q;

endmodule
